// File: rtl/writeback_pipe.sv
// rtl/writeback_pipe.sv - registered writeback stage with handshake, link/r0 handling and retire counter
// Define WB_SUBWORD_EN to format byte/half loads from in_size, in_sext and in_addr_lo.
module writeback_pipe #(
  parameter int          DATA_W   = 32,
  parameter int          REG_AW   = 5,
  parameter int          LINK_REG = 31,
  parameter logic [5:0]  JAL_OP   = 6'b100000,
  parameter logic [5:0]  JALR_OP  = 6'b010001,
  parameter int          CNT_W    = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_o,
  input  logic [DATA_W-1:0] in_d,
  input  logic [31:0]       in_insn,
  input  logic [5:0]        in_aluop,
  input  logic              in_rwe,
  input  logic              in_rdst,
  input  logic              in_rwd,
  input  logic [1:0]        in_size,
  input  logic              in_sext,
  input  logic [1:0]        in_addr_lo,
  input  logic              stall,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retired
);

  logic              valid_q, valid_d;
  logic              rwe_q, rwe_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              is_link;
  logic              accept;
  logic              commit;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] ld_data;

  logic unused_insn;
  assign unused_insn = ^{in_insn[31:21], in_insn[10:0]};

`ifdef WB_SUBWORD_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = in_d[{in_addr_lo, 3'b000} +: 8];
    ld_half = in_d[{in_addr_lo[1], 4'b0000} +: 16];
    ld_data = in_d;
    if (in_size == 2'b00) begin
      ld_data = {{(DATA_W-8){in_sext & ld_byte[7]}}, ld_byte};
    end else if (in_size == 2'b01) begin
      ld_data = {{(DATA_W-16){in_sext & ld_half[15]}}, ld_half};
    end
  end
`else
  logic unused_fmt;
  assign unused_fmt = ^{in_size, in_sext, in_addr_lo};
  assign ld_data    = in_d;
`endif

  assign is_link  = (in_aluop == JAL_OP) || (in_aluop == JALR_OP);
  assign in_ready = !valid_q || !stall;
  assign accept   = in_valid && in_ready;
  assign commit   = valid_q && !stall;

  always_comb begin
    dest = REG_AW'(in_insn[20:16]);
    if (is_link) begin
      dest = REG_AW'(LINK_REG);
    end else if (in_rdst) begin
      dest = REG_AW'(in_insn[15:11]);
    end
  end

  // Accept takes priority over the commit-driven clear so back-to-back flow has no bubble.
  always_comb begin
    valid_d   = valid_q;
    rwe_d     = rwe_q;
    addr_d    = addr_q;
    data_d    = data_q;
    retired_d = retired_q + CNT_W'(commit);
    if (accept) begin
      valid_d = 1'b1;
      rwe_d   = in_rwe;
      addr_d  = dest;
      data_d  = (is_link || !in_rwd) ? in_o : ld_data;
    end else if (commit) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      rwe_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rwe_q     <= rwe_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      retired_q <= retired_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_we    = valid_q && rwe_q && (addr_q != '0);
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_pipe.sv
// tb/tb_writeback_pipe.sv - randomized and directed checks of writeback_pipe against a behavioural model
module tb_writeback_pipe;

  localparam logic [5:0] JAL  = 6'b100000;
  localparam logic [5:0] JALR = 6'b010001;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_o = '0;
  logic [31:0] in_d = '0;
  logic [31:0] in_insn = '0;
  logic [5:0]  in_aluop = '0;
  logic        in_rwe = 1'b0;
  logic        in_rdst = 1'b0;
  logic        in_rwd = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_sext = 1'b0;
  logic [1:0]  in_addr_lo = '0;
  logic        stall = 1'b0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retired;

  writeback_pipe dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_o(in_o), .in_d(in_d), .in_insn(in_insn), .in_aluop(in_aluop),
    .in_rwe(in_rwe), .in_rdst(in_rdst), .in_rwd(in_rwd), .in_size(in_size),
    .in_sext(in_sext), .in_addr_lo(in_addr_lo), .stall(stall),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retired(retired)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_valid;
  bit          m_rwe;
  int unsigned m_addr;
  int unsigned m_data;
  int unsigned m_ret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned exp_dest();
    if (in_aluop == JAL || in_aluop == JALR) return 31;
    if (in_rdst) return in_insn[15:11];
    return in_insn[20:16];
  endfunction

  function automatic int unsigned exp_data();
    int unsigned v;
    if (in_aluop == JAL || in_aluop == JALR || !in_rwd) return in_o;
`ifdef WB_SUBWORD_EN
    if (in_size[1]) return in_d;
    if (in_size == 2'b00) begin
      v = (in_d >> (8 * in_addr_lo)) & 32'hFF;
      if (in_sext && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (in_d >> (16 * in_addr_lo[1])) & 32'hFFFF;
      if (in_sext && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
`else
    return in_d;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rwe = 0; m_addr = 0; m_data = 0; m_ret = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"}, in_ready, !m_valid || !stall);
    check({tag, ".wb_valid"}, wb_valid, m_valid);
    check({tag, ".wb_we"},    wb_we,    m_valid && m_rwe && m_addr != 0);
    check({tag, ".wb_addr"},  wb_addr,  m_addr);
    check({tag, ".wb_data"},  wb_data,  m_data);
    check({tag, ".retired"},  retired,  m_ret);
  endtask

  // Inputs are set at the negedge by the caller; check, clock, update the model.
  task automatic cycle(input string tag);
    bit rdy, acc, com;
    #1 check_outputs(tag);
    @(posedge clock);
    rdy = !m_valid || !stall;
    acc = in_valid && rdy;
    com = m_valid && !stall;
    if (com) m_ret = m_ret + 1;
    if (acc) begin
      m_valid = 1; m_rwe = in_rwe; m_addr = exp_dest(); m_data = exp_data();
    end else if (com) begin
      m_valid = 0;
    end
    @(negedge clock);
  endtask

  task automatic set_alu(input int unsigned o, input int unsigned rd, input int unsigned rt, input bit rdst);
    in_valid = 1; in_o = o; in_d = $urandom; in_aluop = 6'h01;
    in_insn = {11'h0, 5'(rt), 5'(rd), 11'h0};
    in_rwe = 1; in_rdst = rdst; in_rwd = 0; in_size = 2'b10; in_sext = 0; in_addr_lo = 0;
  endtask

  task automatic randomize_inputs();
    int unsigned r;
    in_valid = ($urandom_range(9) < 7);
    stall    = ($urandom_range(9) < 3);
    in_o     = $urandom;
    in_d     = $urandom;
    in_insn  = $urandom;
    r = $urandom_range(7);
    in_aluop = (r == 0) ? JAL : (r == 1) ? JALR : 6'($urandom);
    in_rwe   = $urandom_range(1);
    in_rdst  = $urandom_range(1);
    in_rwd   = $urandom_range(1);
    in_size  = $urandom_range(3);
    in_sext  = $urandom_range(1);
    in_addr_lo = $urandom_range(3);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.wb_valid", wb_valid, 1'b0);
    check("reset.retired", retired, 32'd0);
    @(negedge clock);
    resetn = 1;

    set_alu(32'h1234_5678, 7, 0, 1);
    cycle("alu");
    in_valid = 0;
    cycle("alu_out");
    check("alu.wb_data", wb_data, 32'h1234_5678);
    check("alu.wb_addr", wb_addr, 5'd7);
    check("alu.retired", retired, 32'd1);

    set_alu(32'h0040_0008, 9, 3, 0);
    in_aluop = JAL;
    cycle("jal");
    in_valid = 0;
    #1 check("jal.wb_addr", wb_addr, 5'd31);
    check("jal.wb_data", wb_data, 32'h0040_0008);
    cycle("jal_out");

    set_alu(32'hDEAD_BEEF, 0, 0, 0);
    cycle("r0");
    in_valid = 0;
    #1 check("r0.wb_we", wb_we, 1'b0);
    check("r0.wb_valid", wb_valid, 1'b1);
    cycle("r0_out");
    check("r0.retired", retired, 32'd3);

    set_alu(32'hAAAA_0001, 4, 0, 1);
    cycle("stall_a");
    set_alu(32'hBBBB_0002, 5, 0, 1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("stall_hold");
      check("stall.frozen_data", wb_data, 32'hAAAA_0001);
    end
    stall = 0;
    cycle("stall_release");
    in_valid = 0;
    #1 check("stall.no_bubble", wb_data, 32'hBBBB_0002);
    check("stall.retired", retired, 32'd4);
    cycle("stall_drain");

    set_alu(32'h0, 2, 0, 1);
    in_d = 32'h80FF_7F01; in_rwd = 1; in_size = 2'b00; in_addr_lo = 3; in_sext = 1;
    cycle("ld_byte");
`ifdef WB_SUBWORD_EN
    #1 check("ld_byte.const", wb_data, 32'hFFFF_FF80);
`else
    #1 check("ld_byte.const", wb_data, 32'h80FF_7F01);
`endif
    in_size = 2'b01; in_addr_lo = 2; in_sext = 0;
    cycle("ld_half");
`ifdef WB_SUBWORD_EN
    #1 check("ld_half.const", wb_data, 32'h0000_80FF);
`else
    #1 check("ld_half.const", wb_data, 32'h80FF_7F01);
`endif
    in_valid = 0;
    cycle("ld_drain");

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle("rand");
    end

    set_alu(32'h5555_5555, 6, 0, 1);
    stall = 0;
    cycle("rst_load");
    stall = 1;
    cycle("rst_stall");
    #2 resetn = 0;
    #1;
    model_reset();
    check("rst.wb_valid", wb_valid, 1'b0);
    check("rst.wb_we", wb_we, 1'b0);
    check("rst.wb_addr", wb_addr, 5'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.retired", retired, 32'd0);
    check("rst.in_ready", in_ready, 1'b1);
    @(negedge clock);
    in_valid = 0; stall = 0;
    resetn = 1;
    cycle("post_rst");
    check("post_rst.retired", retired, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
